// File: rtl/npc_pkg.sv
// Shared NPC core constants and basic datapath types.
package npc_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = $clog2(NREG);

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xword_t;

endpackage

// File: rtl/gpr_cell.sv
// One architectural register: data word plus its busy (pending result) flag.
module gpr_cell #(
  parameter int unsigned XLEN = npc_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_wen,
  input  logic [XLEN-1:0] i_wdata,
  input  logic            i_rsv,
  output logic [XLEN-1:0] o_data,
  output logic            o_busy
);

  logic [XLEN-1:0] r_data;
  logic            r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_busy <= 1'b0;
    end else begin
      if (i_wen) begin
        r_data <= i_wdata;
      end
      // A fresh reservation outranks the clear from a same-edge writeback.
      if (i_rsv) begin
        r_busy <= 1'b1;
      end else if (i_wen) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_data = r_data;
  assign o_busy = r_busy;

endmodule

// File: rtl/gpr_file.sv
// General-purpose register file with busy-bit scoreboard, two combinational
// read ports, one write port and optional write-to-read bypass.
module gpr_file #(
  parameter int unsigned XLEN   = npc_pkg::XLEN,
  parameter int unsigned NREG   = npc_pkg::NREG,
  parameter int unsigned AW     = $clog2(NREG),
  parameter bit          BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            rbusy1,
  output logic            rbusy2,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            rsv_en,
  input  logic [AW-1:0]   rsv_addr,
  output logic            rsv_ok,
  output logic            err
);

  // Every encodable address gets a slot; x0 and out-of-range slots are tied to zero.
  localparam int unsigned NSLOT = 32'(1) << AW;

  logic [XLEN-1:0] w_data [NSLOT];
  logic            w_busy [NSLOT];
  logic            w_wvalid;
  logic            w_rsv_ok;
  logic [XLEN-1:0] w_rdata1;
  logic [XLEN-1:0] w_rdata2;
  logic            w_rbusy1;
  logic            w_rbusy2;
  logic            r_err;

  assign w_wvalid = wen && (waddr != '0) && (32'(waddr) < NREG);

  for (genvar gi = 0; gi < int'(NSLOT); gi++) begin : g_slot
    if ((gi > 0) && (gi < int'(NREG))) begin : g_cell
      gpr_cell #(
        .XLEN (XLEN)
      ) u_cell (
        .clk     (clk),
        .rst_n   (rst),
        .i_wen   (wen && (waddr == AW'(gi))),
        .i_wdata (wdata),
        .i_rsv   (rsv_en && w_rsv_ok && (rsv_addr == AW'(gi))),
        .o_data  (w_data[gi]),
        .o_busy  (w_busy[gi])
      );
    end else begin : g_zero
      assign w_data[gi] = '0;
      assign w_busy[gi] = 1'b0;
    end
  end

  // Read ports, with same-cycle writeback forwarded when bypass is enabled.
  always_comb begin
    w_rdata1 = w_data[raddr1];
    w_rbusy1 = w_busy[raddr1];
    w_rdata2 = w_data[raddr2];
    w_rbusy2 = w_busy[raddr2];
    if (BYPASS && w_wvalid && (waddr == raddr1)) begin
      w_rdata1 = wdata;
      w_rbusy1 = 1'b0;
    end
    if (BYPASS && w_wvalid && (waddr == raddr2)) begin
      w_rdata2 = wdata;
      w_rbusy2 = 1'b0;
    end
  end

  // A register being written back this cycle may be re-reserved at the same edge.
  assign w_rsv_ok = !w_busy[rsv_addr] || (wen && (waddr == rsv_addr));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (rsv_en && !w_rsv_ok) begin
      r_err <= 1'b1;
    end
  end

  assign rdata1 = w_rdata1;
  assign rdata2 = w_rdata2;
  assign rbusy1 = w_rbusy1;
  assign rbusy2 = w_rbusy2;
  assign rsv_ok = w_rsv_ok;
  assign err    = r_err;

endmodule

// File: tb/tb_gpr_file.sv
// Bench for gpr_file: three configurations (bypass, no bypass, NREG=16) on shared inputs.
module tb_gpr_file;

  logic        clk;
  logic        rst;
  logic [4:0]  raddr1, raddr2, waddr, rsv_addr;
  logic        wen, rsv_en;
  logic [31:0] wdata;

  logic [31:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2, c_rdata1, c_rdata2;
  logic        a_rbusy1, a_rbusy2, b_rbusy1, b_rbusy2, c_rbusy1, c_rbusy2;
  logic        a_ok, b_ok, c_ok, a_err, b_err, c_err;

  logic [31:0] rd1 [3];
  logic [31:0] rd2 [3];
  logic        rb1 [3];
  logic        rb2 [3];
  logic        ok  [3];
  logic        er  [3];

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: one architectural view per configuration.
  logic [31:0] m_regs [3][32];
  logic        m_busy [3][32];
  logic        m_err  [3];

  gpr_file #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(a_rdata1), .rdata2(a_rdata2), .rbusy1(a_rbusy1), .rbusy2(a_rbusy2),
    .wen(wen), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_ok(a_ok), .err(a_err));

  gpr_file #(.XLEN(32), .NREG(32), .AW(5), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(b_rdata1), .rdata2(b_rdata2), .rbusy1(b_rbusy1), .rbusy2(b_rbusy2),
    .wen(wen), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_ok(b_ok), .err(b_err));

  gpr_file #(.XLEN(32), .NREG(16), .AW(5), .BYPASS(1'b1)) dut_c (
    .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(c_rdata1), .rdata2(c_rdata2), .rbusy1(c_rbusy1), .rbusy2(c_rbusy2),
    .wen(wen), .waddr(waddr), .wdata(wdata), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_ok(c_ok), .err(c_err));

  assign rd1[0] = a_rdata1; assign rd1[1] = b_rdata1; assign rd1[2] = c_rdata1;
  assign rd2[0] = a_rdata2; assign rd2[1] = b_rdata2; assign rd2[2] = c_rdata2;
  assign rb1[0] = a_rbusy1; assign rb1[1] = b_rbusy1; assign rb1[2] = c_rbusy1;
  assign rb2[0] = a_rbusy2; assign rb2[1] = b_rbusy2; assign rb2[2] = c_rbusy2;
  assign ok[0]  = a_ok;     assign ok[1]  = b_ok;     assign ok[2]  = c_ok;
  assign er[0]  = a_err;    assign er[1]  = b_err;    assign er[2]  = c_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int nreg_of(input int k);
    return (k == 2) ? 16 : 32;
  endfunction

  function automatic bit byp_of(input int k);
    return k != 1;
  endfunction

  function automatic bit valid(input int k, input logic [4:0] a);
    return (a != 5'd0) && (int'(a) < nreg_of(k));
  endfunction

  function automatic logic [31:0] exp_rdata(input int k, input logic [4:0] a);
    if (!valid(k, a)) return 32'd0;
    if (byp_of(k) && wen && waddr == a) return wdata;
    return m_regs[k][a];
  endfunction

  function automatic logic exp_rbusy(input int k, input logic [4:0] a);
    if (!valid(k, a)) return 1'b0;
    if (byp_of(k) && wen && waddr == a) return 1'b0;
    return m_busy[k][a];
  endfunction

  function automatic logic exp_ok(input int k);
    return !valid(k, rsv_addr) || !m_busy[k][rsv_addr] || (wen && waddr == rsv_addr);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_err[k] = 1'b0;
      for (int r = 0; r < 32; r++) begin
        m_regs[k][r] = 32'd0;
        m_busy[k][r] = 1'b0;
      end
    end
  endtask

  // Advance the reference model by one clock edge, then the clock itself.
  task automatic apply_edge();
    logic okk;
    for (int k = 0; k < 3; k++) begin
      if (!rst) continue;
      okk = exp_ok(k);
      if (rsv_en && !okk) m_err[k] = 1'b1;
      if (wen && valid(k, waddr)) begin
        m_regs[k][waddr] = wdata;
        m_busy[k][waddr] = 1'b0;
      end
      if (rsv_en && okk && valid(k, rsv_addr)) m_busy[k][rsv_addr] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen = 1'b0; rsv_en = 1'b0; waddr = 5'd0; rsv_addr = 5'd0; wdata = 32'd0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i); rsv_addr = 5'(i);
      #1;
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if (rd1[k] !== 32'd0 || rd2[k] !== 32'd0 || rb1[k] !== 1'b0 || rb2[k] !== 1'b0 ||
            ok[k] !== 1'b1 || er[k] !== 1'b0)
          $display("FAIL reset dut%0d x%0d: got rd=%h/%h rb=%b/%b ok=%b err=%b want zeros ok=1",
                   k, i, rd1[k], rd2[k], rb1[k], rb2[k], ok[k], er[k]);
        else n_pass++;
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    rsv_addr = 5'd0;
  endtask

  task automatic test_x0();
    wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (rd1[k] !== 32'd0) $display("FAIL x0_bypass dut%0d: got %h want 0", k, rd1[k]);
      else n_pass++;
    end
    apply_edge();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (rd1[k] !== 32'd0 || ok[k] !== 1'b1)
        $display("FAIL x0_write dut%0d: got rd=%h ok=%b want 0 ok=1", k, rd1[k], ok[k]);
      else n_pass++;
    end
    apply_edge();
    idle();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (rb1[k] !== 1'b0 || er[k] !== 1'b0)
        $display("FAIL x0_reserve dut%0d: got rb=%b err=%b want 0 0", k, rb1[k], er[k]);
      else n_pass++;
    end
  endtask

  task automatic test_bypass();
    wen = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678; raddr1 = 5'd7;
    #1;
    n_total++;
    if (rd1[0] !== 32'h1234_5678) $display("FAIL bypass_same dut0: got %h want 12345678", rd1[0]);
    else n_pass++;
    n_total++;
    if (rd1[1] !== 32'd0) $display("FAIL nobypass_same dut1: got %h want 0", rd1[1]);
    else n_pass++;
    apply_edge();
    idle();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (rd1[k] !== 32'h1234_5678) $display("FAIL bypass_next dut%0d: got %h want 12345678", k, rd1[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reserve();
    raddr1 = 5'd3; rsv_en = 1'b1; rsv_addr = 5'd3;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (ok[k] !== 1'b1 || rb1[k] !== 1'b0)
        $display("FAIL rsv_first dut%0d: got ok=%b rb=%b want 1 0", k, ok[k], rb1[k]);
      else n_pass++;
    end
    apply_edge();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (ok[k] !== 1'b0 || rb1[k] !== 1'b1)
        $display("FAIL rsv_busy dut%0d: got ok=%b rb=%b want 0 1", k, ok[k], rb1[k]);
      else n_pass++;
    end
    apply_edge();
    idle();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (er[k] !== 1'b1 || rb1[k] !== 1'b1)
        $display("FAIL rsv_err dut%0d: got err=%b rb=%b want 1 1", k, er[k], rb1[k]);
      else n_pass++;
    end
    wen = 1'b1; waddr = 5'd3; wdata = 32'h42;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (byp_of(k) ? (rb1[k] !== 1'b0 || rd1[k] !== 32'h42) : (rb1[k] !== 1'b1 || rd1[k] !== 32'd0))
        $display("FAIL clear_same dut%0d: got rd=%h rb=%b bypass=%0d", k, rd1[k], rb1[k], byp_of(k));
      else n_pass++;
    end
    apply_edge();
    idle();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (rd1[k] !== 32'h42 || rb1[k] !== 1'b0 || er[k] !== 1'b1)
        $display("FAIL clear_next dut%0d: got rd=%h rb=%b err=%b want 42 0 1", k, rd1[k], rb1[k], er[k]);
      else n_pass++;
    end
  endtask

  task automatic test_same_edge();
    rsv_en = 1'b1; rsv_addr = 5'd4; raddr1 = 5'd4;
    apply_edge();
    wen = 1'b1; waddr = 5'd4; wdata = 32'hA5;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (ok[k] !== 1'b1) $display("FAIL same_edge_ok dut%0d: got %b want 1", k, ok[k]);
      else n_pass++;
    end
    apply_edge();
    idle();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (rd1[k] !== 32'hA5 || rb1[k] !== 1'b1 || er[k] !== 1'b0)
        $display("FAIL same_edge dut%0d: got rd=%h rb=%b err=%b want a5 1 0", k, rd1[k], rb1[k], er[k]);
      else n_pass++;
    end
  endtask

  task automatic test_range();
    wen = 1'b1; waddr = 5'd20; wdata = 32'h5555_AAAA;
    apply_edge();
    idle();
    rsv_en = 1'b1; rsv_addr = 5'd20;
    apply_edge();
    idle();
    raddr1 = 5'd20; raddr2 = 5'd20; rsv_addr = 5'd20;
    #1;
    n_total++;
    if (c_rdata1 !== 32'd0 || c_rbusy1 !== 1'b0 || c_ok !== 1'b1 || c_err !== 1'b0)
      $display("FAIL range_c: got rd=%h rb=%b ok=%b err=%b want 0 0 1 0", c_rdata1, c_rbusy1, c_ok, c_err);
    else n_pass++;
    n_total++;
    if (a_rdata2 !== 32'h5555_AAAA || a_rbusy2 !== 1'b1 || a_ok !== 1'b0)
      $display("FAIL range_a: got rd=%h rb=%b ok=%b want 5555aaaa 1 0", a_rdata2, a_rbusy2, a_ok);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    wen = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    apply_edge();
    idle();
    raddr1 = 5'd5;
    #1;
    n_total++;
    if (a_rdata1 !== 32'hDEAD_BEEF) $display("FAIL pre_reset dut0: got %h want deadbeef", a_rdata1);
    else n_pass++;
    #1;
    rst = 1'b0;
    model_clear();
    #1;
    for (int k = 0; k < 3; k++) begin
      n_total++;
      if (rd1[k] !== 32'd0 || er[k] !== 1'b0 || rb2[k] !== 1'b0)
        $display("FAIL async_reset dut%0d: got rd=%h err=%b rb2=%b want 0", k, rd1[k], er[k], rb2[k]);
      else n_pass++;
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      wen      = ($urandom_range(0, 2) != 0);
      waddr    = rand_addr();
      wdata    = $urandom;
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = ($urandom_range(0, 3) == 0) ? waddr : rand_addr();
      raddr1   = ($urandom_range(0, 3) == 0) ? waddr : rand_addr();
      raddr2   = rand_addr();
      #1;
      for (int k = 0; k < 3; k++) begin
        n_total++;
        if (rd1[k] !== exp_rdata(k, raddr1) || rd2[k] !== exp_rdata(k, raddr2) ||
            rb1[k] !== exp_rbusy(k, raddr1) || rb2[k] !== exp_rbusy(k, raddr2) ||
            ok[k] !== exp_ok(k) || er[k] !== m_err[k])
          $display("FAIL random c%0d dut%0d: got rd=%h/%h rb=%b/%b ok=%b err=%b want rd=%h/%h rb=%b/%b ok=%b err=%b",
                   c, k, rd1[k], rd2[k], rb1[k], rb2[k], ok[k], er[k],
                   exp_rdata(k, raddr1), exp_rdata(k, raddr2), exp_rbusy(k, raddr1),
                   exp_rbusy(k, raddr2), exp_ok(k), m_err[k]);
        else n_pass++;
      end
      apply_edge();
      if (c == 200) do_reset();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    raddr1 = 5'd0;
    raddr2 = 5'd0;
    model_clear();
    #2;
    test_reset();
    test_x0();
    test_bypass();
    test_reserve();
    do_reset();
    test_same_edge();
    test_range();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
